// File: rtl/scan_capture.sv
// scan_capture: synchronizes a multiplexed 7-column x 5-row panel scan,
// debounces each column strobe and assembles a 35-bit frame. The frame is
// published only after all columns 0..6 are captured in order.
//
// Interface contract: there is no handshake. frame_valid and err are
// single-cycle pulses. frame, err_count and frame_count are level outputs
// that hold their value between updates.
module scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  col_in,
  input  logic [4:0]  row_in,
  output logic [34:0] frame,
  output logic        frame_valid,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [7:0]  frame_count
);

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    CAPTURE   = 1'b1
  } state_t;

  // Synchronizer stages.
  logic [6:0]  col_s1_q, col_s2_q;
  logic [4:0]  row_s1_q, row_s2_q;

  // Stability tracking.
  logic [11:0] prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        changed;
  logic        accept;

  // Capture datapath and FSM.
  state_t      state_q, state_d;
  logic [2:0]  exp_q, exp_d;
  logic [34:0] shadow_q, shadow_d;
  logic        commit_q, commit_d;
  logic        err_d;
  logic        multi;
  logic [2:0]  col_idx;

  // Published outputs.
  logic [34:0] frame_q;
  logic        frame_valid_q;
  logic        err_q;
  logic [7:0]  err_count_q;
  logic [7:0]  frame_count_q;

  logic [6:0]  sc;
  logic [4:0]  sr;

  assign sc = col_s2_q;
  assign sr = row_s2_q;

  // Two-flop synchronizers for the asynchronous panel lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
      row_s1_q <= '0;
      row_s2_q <= '0;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  // Stability counter. Acceptance fires only on the cycle the count first
  // reaches the limit; a held value then stays saturated without re-firing.
  always_comb begin
    changed = ({sc, sr} != prev_q);
    cnt_d   = cnt_q;
    if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q < STABLE_LIM) begin
      cnt_d = cnt_q + 4'd1;
    end
    accept = (cnt_d == STABLE_LIM) && (changed || (cnt_q != STABLE_LIM));
  end

  // Stability state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= {sc, sr};
      cnt_q  <= cnt_d;
    end
  end

  // Decode the column strobe: multi-hot detection and the one-hot index.
  always_comb begin
    multi   = |(sc & (sc - 7'd1));
    col_idx = '0;
    for (int i = 0; i < 7; i++) begin
      if (sc[i]) col_idx = 3'(i);
    end
  end

  // Capture FSM: next state, shadow buffer writes, error and commit requests.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (accept && (sc != '0)) begin
      if (multi) begin
        err_d   = 1'b1;
        state_d = WAIT_SYNC;
      end else begin
        case (state_q)
          WAIT_SYNC: begin
            if (col_idx == 3'd0) begin
              shadow_d[4:0] = sr;
              exp_d         = 3'd1;
              state_d       = CAPTURE;
            end
          end
          CAPTURE: begin
            if (col_idx == exp_q) begin
              shadow_d[int'(exp_q)*5 +: 5] = sr;
              if (exp_q == 3'd6) begin
                commit_d = 1'b1;
                exp_d    = 3'd0;
                state_d  = WAIT_SYNC;
              end else begin
                exp_d = exp_q + 3'd1;
              end
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_SYNC;
              // An out-of-order column 0 restarts capture immediately.
              if (col_idx == 3'd0) begin
                shadow_d[4:0] = sr;
                exp_d         = 3'd1;
                state_d       = CAPTURE;
              end
            end
          end
          default: state_d = WAIT_SYNC;
        endcase
      end
    end
  end

  // FSM and shadow buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_SYNC;
      exp_q    <= '0;
      shadow_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      commit_q <= commit_d;
    end
  end

  // Output registers: frame publish one cycle after column 6, error counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      frame_valid_q <= commit_q;
      err_q         <= err_d;
      if (commit_q) begin
        frame_q       <= shadow_q;
        frame_count_q <= frame_count_q + 8'd1;
      end
      if (err_d && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: directed scans against a behavioural model of the
// panel capture rules, plus literal expectations after each scenario.
module tb_scan_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  col_in = '0;
  logic [4:0]  row_in = '0;
  logic [34:0] frame;
  logic        frame_valid;
  logic        err;
  logic [7:0]  err_count;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int err_seen = 0;

  scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .row_in      (row_in),
    .frame       (frame),
    .frame_valid (frame_valid),
    .err         (err),
    .err_count   (err_count),
    .frame_count (frame_count)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [11:0] m_p1 = '0, m_p2 = '0, m_last = '0;
  int          m_run = 0;
  bit          m_cap = 0;
  int          m_next = 0;
  logic [34:0] m_shadow = '0;
  bit          m_pend = 0;
  logic [34:0] m_frame = '0;
  logic        m_fv = 0, m_err = 0;
  logic [7:0]  m_ecnt = '0, m_fcnt = '0;

  always @(posedge clk or posedge rst) begin
    logic [11:0] cur;
    int idx;
    int ones;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_last = '0; m_run = 0;
      m_cap = 0; m_next = 0; m_shadow = '0; m_pend = 0;
      m_frame = '0; m_fv = 0; m_err = 0; m_ecnt = '0; m_fcnt = '0;
    end else begin
      m_fv  = 0;
      m_err = 0;
      if (m_pend) begin
        m_frame = m_shadow;
        m_fv    = 1;
        m_fcnt  = m_fcnt + 8'd1;
        m_pend  = 0;
      end
      cur  = m_p2;
      m_p2 = m_p1;
      m_p1 = {col_in, row_in};
      if (cur == m_last) begin
        if (m_run < 1000000) m_run++;
      end else begin
        m_run = 1;
      end
      m_last = cur;
      if (m_run == S) begin
        ones = $countones(cur[11:5]);
        idx  = 0;
        for (int i = 0; i < 7; i++) if (cur[5+i]) idx = i;
        if (ones > 1) begin
          m_err = 1;
          m_cap = 0;
        end else if (ones == 1) begin
          if (m_cap && idx == m_next) begin
            m_shadow[idx*5 +: 5] = cur[4:0];
            m_next++;
            if (m_next == 7) begin
              m_pend = 1;
              m_cap  = 0;
            end
          end else begin
            if (m_cap) begin
              m_err = 1;
              m_cap = 0;
            end
            if (idx == 0) begin
              m_shadow[4:0] = cur[4:0];
              m_next = 1;
              m_cap  = 1;
            end
          end
        end
      end
      if (m_err && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("frame", frame, m_frame);
    chk("frame_valid", 35'(frame_valid), 35'(m_fv));
    chk("err", 35'(err), 35'(m_err));
    chk("err_count", 35'(err_count), 35'(m_ecnt));
    chk("frame_count", 35'(frame_count), 35'(m_fcnt));
    if (frame_valid === 1'b1) fv_seen++;
    if (err === 1'b1) err_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic drive(input logic [6:0] c, input logic [4:0] r, input int n);
    col_in = c;
    row_in = r;
    tick(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic scan(input logic [34:0] pat, input int hold, input int blank);
    logic [6:0] one;
    one = 7'd1;
    for (int c = 0; c < 7; c++) begin
      drive(one << c, pat[c*5 +: 5], hold);
      if (blank > 0) drive('0, '0, blank);
    end
    drive('0, '0, 10);
  endtask

  localparam logic [34:0] P1 = 35'h03F041041;
  localparam logic [34:0] P2 = 35'h2A5A5A5A5;

  initial begin
    logic [6:0] one;
    one = 7'd1;
    do_reset();
    chk("reset_frame", frame, 35'd0);
    chk("reset_fcnt", 35'(frame_count), 35'd0);
    chk("reset_ecnt", 35'(err_count), 35'd0);

    // Clean scan, 10 cycles per column.
    fv_seen = 0;
    scan(P1, 10, 0);
    chk("clean_frame", frame, 35'h03F041041);
    chk("clean_fcnt", 35'(frame_count), 35'd1);
    chk("clean_ecnt", 35'(err_count), 35'd0);
    chk("clean_fv_pulses", 35'(fv_seen), 35'd1);

    // Clean scan with 20 blanking cycles between columns.
    do_reset();
    fv_seen = 0;
    err_seen = 0;
    scan(P1, 10, 20);
    chk("blank_frame", frame, 35'h03F041041);
    chk("blank_fcnt", 35'(frame_count), 35'd1);
    chk("blank_err_pulses", 35'(err_seen), 35'd0);

    // Minimum hold of STABLE_CYCLES+1, then a toggling column 6.
    do_reset();
    fv_seen = 0;
    scan(P2, S + 1, 0);
    chk("minhold_frame", frame, P2);
    chk("minhold_fv_pulses", 35'(fv_seen), 35'd1);
    for (int c = 0; c < 6; c++) drive(one << c, P1[c*5 +: 5], S + 1);
    for (int k = 0; k < S; k++) drive(7'h40, (k % 2 == 0) ? 5'h0A : 5'h15, 1);
    drive('0, '0, 10);
    chk("toggle_fv_pulses", 35'(fv_seen), 35'd1);
    chk("toggle_frame", frame, P2);
    chk("toggle_fcnt", 35'(frame_count), 35'd1);

    // Out-of-order sequence 0,1,2,4.
    do_reset();
    err_seen = 0;
    drive(7'h01, 5'h03, 10);
    drive(7'h02, 5'h05, 10);
    drive(7'h04, 5'h09, 10);
    drive(7'h10, 5'h11, 10);
    drive('0, '0, 10);
    chk("order_err_pulses", 35'(err_seen), 35'd1);
    chk("order_ecnt", 35'(err_count), 35'd1);
    chk("order_frame", frame, 35'd0);
    scan(P1, 10, 0);
    chk("order_recover_fcnt", 35'(frame_count), 35'd1);
    chk("order_recover_frame", frame, P1);

    // Multi-hot column during capture.
    err_seen = 0;
    drive(7'h01, 5'h1F, 10);
    drive(7'h02, 5'h1F, 10);
    drive(7'b0000011, 5'h1F, 10);
    drive('0, '0, 10);
    chk("multi_err_pulses", 35'(err_seen), 35'd1);
    chk("multi_ecnt", 35'(err_count), 35'd2);
    for (int c = 2; c < 7; c++) drive(one << c, 5'h1F, 10);
    drive('0, '0, 10);
    chk("multi_fcnt", 35'(frame_count), 35'd1);
    chk("multi_frame", frame, P1);
    chk("multi_ecnt_after", 35'(err_count), 35'd2);

    // Reset mid-frame, recovery, then error counter saturation.
    for (int c = 0; c < 4; c++) drive(one << c, P2[c*5 +: 5], 10);
    rst = 1'b1;
    #1;
    chk("midrst_frame", frame, 35'd0);
    chk("midrst_fv", 35'(frame_valid), 35'd0);
    chk("midrst_err", 35'(err), 35'd0);
    chk("midrst_ecnt", 35'(err_count), 35'd0);
    chk("midrst_fcnt", 35'(frame_count), 35'd0);
    tick(2);
    rst = 1'b0;
    drive('0, '0, 4);
    scan(P1, 10, 0);
    chk("midrst_recover_fcnt", 35'(frame_count), 35'd1);
    chk("midrst_recover_frame", frame, P1);
    err_seen = 0;
    for (int n = 0; n < 300; n++) begin
      drive(7'h01, 5'h01, S + 1);
      drive(7'h04, 5'h04, S + 1);
    end
    drive('0, '0, 10);
    chk("sat_err_pulses", 35'(err_seen), 35'd300);
    chk("sat_ecnt", 35'(err_count), 35'd255);
    chk("sat_frame", frame, P1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
